// File: rtl/ariane_pkg.sv
// Minimal scoreboard-entry definitions shared by the issue path.
// Only the fields the reorder window inspects are modelled: the functional
// unit and the three architectural register specifiers, plus the PC.
package ariane_pkg;

  typedef enum logic [3:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR
  } fu_t;

  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } scoreboard_entry_t;

endpackage

// File: rtl/issue_reorder_window_if.sv
// Handshake bundle between issue-read, the reorder window and issue/execute.
// slave  : the reorder window side.
// master : the surrounding pipeline (or a testbench) driving the window.
// bypass_cnt_o / stall_cnt_o carry statistics; zero unless REORDER_STATS_EN.
interface issue_reorder_window_if #(
  parameter int unsigned CNT_W = 16
);

  logic                          flush_i;
  logic                          debug_req_i;
  ariane_pkg::scoreboard_entry_t issue_entry_i;
  logic                          issue_entry_valid_i;
  logic                          is_ctrl_flow_i;
  logic                          issue_instr_ack_o;
  ariane_pkg::scoreboard_entry_t issue_entry_o;
  logic                          issue_entry_valid_o;
  logic                          is_ctrl_flow_o;
  logic                          issue_instr_ack_i;
  logic                          lsu_ready_i;
  logic [CNT_W-1:0]              bypass_cnt_o;
  logic [CNT_W-1:0]              stall_cnt_o;

  modport slave (
    input  flush_i, debug_req_i, issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i,
    input  issue_instr_ack_i, lsu_ready_i,
    output issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
    output bypass_cnt_o, stall_cnt_o
  );

  modport master (
    output flush_i, debug_req_i, issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i,
    output issue_instr_ack_i, lsu_ready_i,
    input  issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o,
    input  bypass_cnt_o, stall_cnt_o
  );

endinterface

// File: rtl/issue_reorder_window.sv
// Issue reorder window: buffers up to DEPTH scoreboard entries in program
// order between issue-read and issue/execute. When the oldest entry is a
// load/store stuck behind a busy LSU, a younger independent ALU-type entry
// (within MAX_BYPASS slots) may issue ahead of it.
//
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-high reset
//   bus    - issue_reorder_window_if.slave: enqueue handshake (issue_entry_*_i,
//            issue_instr_ack_o), dequeue handshake (issue_entry_*_o,
//            issue_instr_ack_i), flush_i, debug_req_i, lsu_ready_i, statistics.
//
// Optional: define REORDER_STATS_EN to build saturating bypass/stall counters;
// otherwise the counter outputs are tied to zero.
module issue_reorder_window #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_BYPASS = 2,
  parameter int unsigned CNT_W      = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  issue_reorder_window_if.slave bus
);

  import ariane_pkg::*;

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  scoreboard_entry_t sbe_q [DEPTH];
  scoreboard_entry_t sbe_d [DEPTH];
  logic [DEPTH-1:0]  cf_q, cf_d, vld_q, vld_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_mid;
  logic [DEPTH-1:0]  cand_ok;
  logic [IdxW-1:0]   sel_idx;
  logic              bypass_en, out_valid, acc, enq, deq;

  function automatic logic is_mem(fu_t fu);
    return (fu == LOAD) || (fu == STORE);
  endfunction

  // RAW / WAR / WAW between a younger and an older entry; x0 never conflicts.
  function automatic logic has_hazard(scoreboard_entry_t yng, scoreboard_entry_t old);
    logic raw, war, waw;
    raw = ((yng.rs1 != '0) && (yng.rs1 == old.rd)) || ((yng.rs2 != '0) && (yng.rs2 == old.rd));
    war = (yng.rd != '0) && ((yng.rd == old.rs1) || (yng.rd == old.rs2));
    waw = (yng.rd != '0) && (yng.rd == old.rd);
    return raw | war | waw;
  endfunction

  // Candidate k must be ALU-type and independent of, and not behind a control
  // flow barrier among, every older slot.
  always_comb begin
    cand_ok = '0;
    for (int k = 1; k < int'(DEPTH); k++) begin
      if (k <= int'(MAX_BYPASS)) begin
        cand_ok[k] = vld_q[k] && !is_mem(sbe_q[k].fu) && (sbe_q[k].fu != CTRL_FLOW) && !cf_q[k];
        for (int j = 0; j < k; j++) begin
          if (has_hazard(sbe_q[k], sbe_q[j]) || cf_q[j] || (sbe_q[j].fu == CTRL_FLOW)) begin
            cand_ok[k] = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    bypass_en = vld_q[0] && is_mem(sbe_q[0].fu) && !bus.lsu_ready_i && !bus.debug_req_i;
    sel_idx   = '0;
    // Descending scan so the lowest qualifying index wins.
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      if (bypass_en && cand_ok[k]) sel_idx = IdxW'(k);
    end
  end

  assign out_valid = vld_q[sel_idx];
  assign acc       = (cnt_q < CntW'(DEPTH)) && !bus.flush_i;
  assign enq       = bus.issue_entry_valid_i && acc;
  assign deq       = bus.issue_instr_ack_i && out_valid && !bus.flush_i;
  assign cnt_mid   = cnt_q - CntW'(deq);

  assign bus.issue_instr_ack_o   = acc;
  assign bus.issue_entry_valid_o = out_valid;
  assign bus.issue_entry_o       = out_valid ? sbe_q[sel_idx] : '0;
  assign bus.is_ctrl_flow_o      = out_valid && cf_q[sel_idx];

  always_comb begin
    // Remove the selected slot and compact younger slots down by one.
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      if (deq && (i >= int'(sel_idx))) begin
        sbe_d[i] = sbe_q[i+1];
        cf_d[i]  = cf_q[i+1];
        vld_d[i] = vld_q[i+1];
      end else begin
        sbe_d[i] = sbe_q[i];
        cf_d[i]  = cf_q[i];
        vld_d[i] = vld_q[i];
      end
    end
    sbe_d[DEPTH-1] = deq ? '0 : sbe_q[DEPTH-1];
    cf_d[DEPTH-1]  = deq ? 1'b0 : cf_q[DEPTH-1];
    vld_d[DEPTH-1] = deq ? 1'b0 : vld_q[DEPTH-1];
    cnt_d          = cnt_mid;
    // New entry lands behind the youngest slot left after compaction.
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (enq && (CntW'(i) == cnt_mid)) begin
        sbe_d[i] = bus.issue_entry_i;
        cf_d[i]  = bus.is_ctrl_flow_i;
        vld_d[i] = 1'b1;
      end
    end
    if (enq) cnt_d = cnt_mid + CntW'(1);
    if (bus.flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) sbe_d[i] = '0;
      cf_d  = '0;
      vld_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) sbe_q[i] <= '0;
      cf_q  <= '0;
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) sbe_q[i] <= sbe_d[i];
      cf_q  <= cf_d;
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef REORDER_STATS_EN
  logic [CNT_W-1:0] bypass_cnt_q, stall_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bypass_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      if (deq && (sel_idx != '0) && !(&bypass_cnt_q)) bypass_cnt_q <= bypass_cnt_q + CNT_W'(1);
      if (out_valid && !bus.issue_instr_ack_i && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.bypass_cnt_o = bypass_cnt_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
`else
  assign bus.bypass_cnt_o = {CNT_W{1'b0}};
  assign bus.stall_cnt_o  = {CNT_W{1'b0}};
`endif

endmodule
